fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC select,
//  and the IF/ID pipeline register. Consumes pcEnable/ifEnable from the hazard unit,
//  plus redirects from ID (jump/jr) and EX (branch). Feeds decode and the hazard unit.
//  Also counts hazard-stall cycles for performance debug.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  CNT_W     16             width of stall cycle counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  pc_en          in   1      hazard pcEnable; 0 = hold PC
//  if_en          in   1      hazard ifEnable; 0 = hold IF/ID register
//  br_taken       in   1      EX: conditional branch resolved taken
//  br_target      in   32     EX: branch target address
//  jmp            in   1      ID: j/jal
//  jmp_target     in   32     ID: jump target
//  jr             in   1      ID: jr/jalr
//  jr_target      in   32     ID: register target
//  imem_addr      out  32     instruction memory address (= PC, combinational)
//  imem_rdata     in   32     instruction word, combinational read of imem_addr
//  ifid_instr     out  32     IF/ID instruction
//  ifid_pc4       out  32     IF/ID PC+4 of that instruction
//  ifid_valid     out  1      IF/ID holds a live instruction
//  stall_cnt      out  CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset (async, any time incl. mid-stall/redirect): pc=RESET_PC, ifid_instr=0,
//   ifid_pc4=0, ifid_valid=0, stall_cnt=0. First fetch at RESET_PC the cycle reset drops.
//  redirect = br_taken | jmp | jr. Next-PC priority per edge:
//   br_taken > jr > jmp > (pc_en ? pc+4 : pc). Branch wins (older instruction).
//  Redirect ignores pc_en: PC loads the target even when the hazard unit stalls.
//  Target bits [1:0] forced to 00; PC[1:0] always 0.
//  pc+4 wraps mod 2^32 (0xFFFF_FFFC -> 0x0000_0000), no flag.
//  IF/ID update per edge, priority:
//   redirect      -> flush: ifid_instr=0 (NOP), ifid_valid=0, ifid_pc4 holds
//   if_en=0       -> hold all IF/ID fields
//   else          -> ifid_instr=imem_rdata, ifid_pc4=pc+4, ifid_valid=1
//  Latency: instruction at PC appears in IF/ID one edge later; taken branch costs
//   1 flushed slot in IF/ID (EX-side flush of ID is outside this block).
//  stall_cnt: +1 on each edge with pc_en=0 and no redirect; saturates at all-ones.
//  pc_en=1 with if_en=0 (not produced by hazard unit): PC advances, IF/ID holds;
//   the fetched word is dropped. Permitted, not an error.
//  Simultaneous jmp and jr: jr wins. Simultaneous branch + any: branch wins.
// TESTING
//  1 Reset, pc_en=if_en=1, imem_rdata=addr^32'hA5A5_0000 -> ifid_pc4 4,8,C...;
//    ifid_valid=1 from first edge; ifid_instr matches prior address.
//  2 At pc=0x10 drop pc_en=if_en for 2 cycles -> pc stays 0x10, IF/ID frozen,
//    stall_cnt=2; release -> pc=0x14 next edge.
//  3 br_taken, br_target=0x43 -> pc=0x40 next edge, ifid_valid=0, ifid_instr=0;
//    following edge ifid_instr=word@0x40, ifid_pc4=0x44.
//  4 br_taken with pc_en=if_en=0 -> pc=target, IF/ID flushed, stall_cnt unchanged;
//    jmp+jr same cycle -> jr_target taken.
//  5 RESET_PC=0xFFFF_FFF8 -> pc FFFF_FFFC then 0000_0000; force stall_cnt to max,
//    stall again -> stays all-ones.
//  6 Assert reset mid-stall, async between edges -> all outputs reset immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select with branch/jump redirects,
// the IF/ID pipeline register and a saturating hazard-stall cycle counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             if_en,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp,
  input  logic [31:0]      jmp_target,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]      pcReg;
  logic [31:0]      pcPlus4;
  logic [31:0]      nextPc;
  logic             redirect;
  logic             stallCycle;
  logic [CNT_W-1:0] stallCount;

  assign pcPlus4    = pcReg + 32'd4;
  assign redirect   = br_taken | jmp | jr;
  assign stallCycle = ~pc_en & ~redirect;
  assign imem_addr  = pcReg;
  assign stall_cnt  = stallCount;

  // Branch resolves in EX and belongs to the older instruction, so it beats ID jumps;
  // redirects load regardless of pc_en.
  always_comb begin
    nextPc = pcReg;
    if (br_taken) begin
      nextPc = {br_target[31:2], 2'b00};
    end else if (jr) begin
      nextPc = {jr_target[31:2], 2'b00};
    end else if (jmp) begin
      nextPc = {jmp_target[31:2], 2'b00};
    end else if (pc_en) begin
      nextPc = pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg <= RESET_PC_ALIGNED;
    end else begin
      pcReg <= nextPc;
    end
  end

  // A redirect squashes the word fetched down the wrong path; pc4 is left as is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      ifid_instr <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (if_en) begin
      ifid_instr <= imem_rdata;
      ifid_pc4   <= pcPlus4;
      ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
    end else if (stallCycle && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a spec-level model pushes expected IF state
// into a queue per stimulus step; each following clock edge pops and compares.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
  } expT;

  localparam logic [31:0] WORD_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcEn, ifEn, brTaken, jmp, jr;
  logic [31:0] brTarget, jmpTarget, jrTarget;
  logic [31:0] imemAddr, imemRdata, ifidInstr, ifidPc4;
  logic        ifidValid;
  logic [15:0] stallCnt;

  logic        reset2, pcEn2;
  logic [31:0] imemAddr2, imemRdata2, ifidInstr2, ifidPc42;
  logic        ifidValid2;
  logic [1:0]  stallCnt2;

  expT         expQ[$];
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid;
  logic [15:0] mStall;
  int          checkCount = 0;
  int          errorCount = 0;

  always #5 clk = ~clk;

  assign imemRdata  = imemAddr ^ WORD_KEY;
  assign imemRdata2 = imemAddr2 ^ WORD_KEY;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pc_en(pcEn), .if_en(ifEn),
    .br_taken(brTaken), .br_target(brTarget), .jmp(jmp), .jmp_target(jmpTarget),
    .jr(jr), .jr_target(jrTarget), .imem_addr(imemAddr), .imem_rdata(imemRdata),
    .ifid_instr(ifidInstr), .ifid_pc4(ifidPc4), .ifid_valid(ifidValid),
    .stall_cnt(stallCnt)
  );

  // Second instance exercises PC wrap and counter saturation with a 2-bit counter.
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dutWrap (
    .clk(clk), .reset(reset2), .pc_en(pcEn2), .if_en(pcEn2),
    .br_taken(1'b0), .br_target(32'h0), .jmp(1'b0), .jmp_target(32'h0),
    .jr(1'b0), .jr_target(32'h0), .imem_addr(imemAddr2), .imem_rdata(imemRdata2),
    .ifid_instr(ifidInstr2), .ifid_pc4(ifidPc42), .ifid_valid(ifidValid2),
    .stall_cnt(stallCnt2)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mStall = 16'h0;
  endtask

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic applyStimulus(input logic pe, input logic ie, input logic br,
                               input logic [31:0] brT, input logic j, input logic [31:0] jT,
                               input logic r, input logic [31:0] rT);
    logic redir;
    logic [31:0] nPc;
    expT e;
    pcEn = pe; ifEn = ie; brTaken = br; brTarget = brT;
    jmp = j; jmpTarget = jT; jr = r; jrTarget = rT;
    redir = br | j | r;
    if (br)      nPc = {brT[31:2], 2'b00};
    else if (r)  nPc = {rT[31:2], 2'b00};
    else if (j)  nPc = {jT[31:2], 2'b00};
    else if (pe) nPc = mPc + 32'd4;
    else         nPc = mPc;
    if (redir) begin
      mInstr = 32'h0; mValid = 1'b0;
    end else if (ie) begin
      mInstr = mPc ^ WORD_KEY; mPc4 = mPc + 32'd4; mValid = 1'b1;
    end
    if (!pe && !redir && mStall != 16'hFFFF) mStall = mStall + 16'd1;
    mPc = nPc;
    e.pc = mPc; e.instr = mInstr; e.pc4 = mPc4; e.valid = mValid; e.stall = mStall;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    expT e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $error("[TB] FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = expQ.pop_front();
      checkVal({tag, ".pc"},    imemAddr,  e.pc);
      checkVal({tag, ".instr"}, ifidInstr, e.instr);
      checkVal({tag, ".pc4"},   ifidPc4,   e.pc4);
      checkVal({tag, ".valid"}, {31'h0, ifidValid}, {31'h0, e.valid});
      checkVal({tag, ".stall"}, {16'h0, stallCnt},  {16'h0, e.stall});
    end
  endtask

  task automatic step(input string tag, input logic pe, input logic ie, input logic br,
                      input logic [31:0] brT, input logic j, input logic [31:0] jT,
                      input logic r, input logic [31:0] rT);
    applyStimulus(pe, ie, br, brT, j, jT, r, rT);
    checkOutput(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1; pcEn2 = 1'b1;
    pcEn = 1'b1; ifEn = 1'b1; brTaken = 1'b0; jmp = 1'b0; jr = 1'b0;
    brTarget = 32'h0; jmpTarget = 32'h0; jrTarget = 32'h0;
    modelReset();
    #12;
    checkVal("rst.pc",    imemAddr,  32'h0);
    checkVal("rst.instr", ifidInstr, 32'h0);
    checkVal("rst.pc4",   ifidPc4,   32'h0);
    checkVal("rst.valid", {31'h0, ifidValid}, 32'h0);
    checkVal("rst.stall", {16'h0, stallCnt},  32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) step("seq", 1, 1, 0, 0, 0, 0, 0, 0);
    checkVal("seq.pc10", imemAddr, 32'h10);

    step("stall1", 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall2", 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("stall.cnt2", {16'h0, stallCnt}, 32'd2);
    step("release", 1, 1, 0, 0, 0, 0, 0, 0);
    checkVal("release.pc14", imemAddr, 32'h14);

    step("branch", 1, 1, 1, 32'h43, 0, 0, 0, 0);
    checkVal("branch.pc40", imemAddr, 32'h40);
    step("afterBr", 1, 1, 0, 0, 0, 0, 0, 0);
    checkVal("afterBr.instr", ifidInstr, 32'h40 ^ WORD_KEY);

    step("brStalled", 0, 0, 1, 32'h0000_1234, 0, 0, 0, 0);
    step("jmpJr", 1, 1, 0, 0, 1, 32'h0000_2000, 1, 32'h0000_3003);
    checkVal("jmpJr.pc", imemAddr, 32'h3000);
    step("brBeatsAll", 1, 1, 1, 32'h0000_0500, 1, 32'h0000_2000, 1, 32'h0000_3000);
    step("jmpOnly", 1, 1, 0, 0, 1, 32'h0000_0802, 0, 0);
    step("fill", 1, 1, 0, 0, 0, 0, 0, 0);
    step("pcOnly", 1, 0, 0, 0, 0, 0, 0, 0);
    step("resume", 1, 1, 0, 0, 0, 0, 0, 0);

    step("midStall1", 0, 0, 0, 0, 0, 0, 0, 0);
    step("midStall2", 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    checkVal("asyncRst.pc",    imemAddr,  32'h0);
    checkVal("asyncRst.instr", ifidInstr, 32'h0);
    checkVal("asyncRst.pc4",   ifidPc4,   32'h0);
    checkVal("asyncRst.valid", {31'h0, ifidValid}, 32'h0);
    checkVal("asyncRst.stall", {16'h0, stallCnt},  32'h0);
    modelReset();
    #1;
    reset = 1'b0;
    step("postRst", 1, 1, 0, 0, 0, 0, 0, 0);

    checkVal("wrap.rst", imemAddr2, 32'hFFFF_FFF8);
    reset2 = 1'b0;
    @(posedge clk); #1;
    checkVal("wrap.pcFFC", imemAddr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    checkVal("wrap.pc0", imemAddr2, 32'h0);
    checkVal("wrap.pc4", ifidPc42, 32'h0);
    pcEn2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkVal("sat.cnt", {30'h0, stallCnt2}, (i < 3) ? (i + 1) : 3);
    end
    checkVal("sat.pcHold", imemAddr2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
